// File: rtl/parallax_pkg.sv
// Shared constants and LFSR helpers for the parallax background generator.
package parallax_pkg;

    localparam logic [7:0] RIDGE0_TAPS    = 8'b10111000;
    localparam logic [6:0] RIDGE1_TAPS    = 7'b1100000;
    localparam logic [7:0] RIDGE0_SEED    = 8'h60;
    localparam logic [6:0] RIDGE1_SEED    = 7'h30;
    localparam logic [2:0] RIDGE0_RGB     = 3'b010;
    localparam logic [2:0] RIDGE1_RGB     = 3'b100;
    localparam logic [2:0] STAR_FORCE_RGB = 3'b111;

    // Maximal-length taps for a right-shifting Galois LFSR of the given width.
    function automatic logic [23:0] star_taps(input int unsigned w);
        case (w)
            16:      return 24'h00B400;
            17:      return 24'h012000;
            18:      return 24'h020400;
            19:      return 24'h072000;
            20:      return 24'h090000;
            21:      return 24'h140000;
            22:      return 24'h300000;
            23:      return 24'h420000;
            default: return 24'hE10000;
        endcase
    endfunction

    function automatic logic [23:0] lfsr_step(input logic [23:0] s, input logic [23:0] taps);
        return (s >> 1) ^ (s[0] ? taps : 24'd0);
    endfunction

    // Ridge height random walk, wrapping modulo 1024.
    function automatic logic [9:0] height_step(input logic [9:0] h, input logic up);
        return up ? h + 10'd1 : h - 10'd1;
    endfunction

endpackage

// File: rtl/parallax_star_layer.sv
// One starfield layer: per-frame seed, pixel LFSR walking the raster at a
// 2^PITCH_LOG2 horizontal pitch, and the star hit/colour decode.
module parallax_star_layer
    import parallax_pkg::*;
#(
    parameter int unsigned LFSR_W     = 19,
    parameter int unsigned DENSITY    = 10,
    parameter int unsigned PITCH_LOG2 = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] hpos,
    input  logic       active,
    input  logic       vblank,
    input  logic       vblank_start,
    input  logic       scroll_en,
    input  logic [2:0] speed,
    output logic       hit,
    output logic [2:0] colour
);

    localparam logic [23:0] TAPS       = star_taps(LFSR_W);
    localparam logic [9:0]  PITCH_MASK = 10'((1 << PITCH_LOG2) - 1);

    logic [LFSR_W-1:0] seed_q, seed_d;
    logic [LFSR_W-1:0] pix_q, pix_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              on_pitch;

    assign on_pitch = (hpos & PITCH_MASK) == 10'd0;

    always_comb begin
        seed_d = seed_q;
        cnt_d  = cnt_q;
        pix_d  = pix_q;
        if (vblank_start) begin
            cnt_d = scroll_en ? speed : 3'd0;
        end else if (cnt_q != 3'd0) begin
            seed_d = LFSR_W'(lfsr_step(24'(seed_q), TAPS));
            cnt_d  = cnt_q - 3'd1;
        end
        // Reloading every vblank cycle picks up the final seed once stepping ends.
        if (vblank) begin
            pix_d = seed_q;
        end else if (active && on_pitch) begin
            pix_d = LFSR_W'(lfsr_step(24'(pix_q), TAPS));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seed_q <= '1;
            pix_q  <= '1;
            cnt_q  <= 3'd0;
        end else begin
            seed_q <= seed_d;
            pix_q  <= pix_d;
            cnt_q  <= cnt_d;
        end
    end

    assign hit    = active && on_pitch && (&pix_q[LFSR_W-1 -: DENSITY]);
    assign colour = (pix_q[2:0] == 3'd0) ? STAR_FORCE_RGB : pix_q[2:0];

endmodule

// File: rtl/parallax_layers.sv
// Procedural scrolling background: NUM_LAYERS starfields over two random-walk
// mountain ridges, with per-layer programmable scroll speed.
module parallax_layers
    import parallax_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned NUM_LAYERS  = 3,
    parameter int unsigned LFSR_W      = 19,
    parameter int unsigned DENSITY     = 10,
    parameter int unsigned RIDGE0_BASE = 400,
    parameter int unsigned RIDGE1_BASE = 380
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [9:0]                    hpos,
    input  logic [9:0]                    vpos,
    input  logic                          display_on,
    input  logic                          scroll_en,
    input  logic [3*(NUM_LAYERS+2)-1:0]   speed,
    output logic [2:0]                    rgb
);

    localparam int unsigned R0_SPD = 3 * NUM_LAYERS;
    localparam int unsigned R1_SPD = 3 * NUM_LAYERS + 3;

    logic       active, vblank, vblank_start;
    logic [NUM_LAYERS-1:0] star_hit;
    logic [2:0] star_rgb [NUM_LAYERS];
    logic [2:0] pix_rgb, rgb_q, rgb_d;

    logic [7:0] r0_org_lfsr_q, r0_org_lfsr_d, r0_lfsr_q, r0_lfsr_d;
    logic [6:0] r1_org_lfsr_q, r1_org_lfsr_d, r1_lfsr_q, r1_lfsr_d;
    logic [9:0] r0_org_h_q, r0_org_h_d, r0_h_q, r0_h_d;
    logic [9:0] r1_org_h_q, r1_org_h_d, r1_h_q, r1_h_d;
    logic [2:0] r0_cnt_q, r0_cnt_d, r1_cnt_q, r1_cnt_d;

    // Qualify display_on with the active window so a loose sync source cannot paint overscan.
    assign active       = display_on && (hpos < 10'(H_ACTIVE)) && (vpos < 10'(V_ACTIVE));
    assign vblank       = vpos >= 10'(V_ACTIVE);
    assign vblank_start = (vpos == 10'(V_ACTIVE)) && (hpos == 10'd0);

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_star
        parallax_star_layer #(
            .LFSR_W     (LFSR_W),
            .DENSITY    (DENSITY),
            .PITCH_LOG2 (i)
        ) u_star (
            .clk          (clk),
            .reset_n      (reset_n),
            .hpos         (hpos),
            .active       (active),
            .vblank       (vblank),
            .vblank_start (vblank_start),
            .scroll_en    (scroll_en),
            .speed        (speed[3*i +: 3]),
            .hit          (star_hit[i]),
            .colour       (star_rgb[i])
        );
    end

    always_comb begin
        r0_org_lfsr_d = r0_org_lfsr_q;
        r0_org_h_d    = r0_org_h_q;
        r0_cnt_d      = r0_cnt_q;
        r1_org_lfsr_d = r1_org_lfsr_q;
        r1_org_h_d    = r1_org_h_q;
        r1_cnt_d      = r1_cnt_q;
        if (vblank_start) begin
            r0_cnt_d = scroll_en ? speed[R0_SPD +: 3] : 3'd0;
            r1_cnt_d = scroll_en ? speed[R1_SPD +: 3] : 3'd0;
        end else begin
            if (r0_cnt_q != 3'd0) begin
                r0_org_h_d    = height_step(r0_org_h_q, r0_org_lfsr_q[0]);
                r0_org_lfsr_d = 8'(lfsr_step(24'(r0_org_lfsr_q), 24'(RIDGE0_TAPS)));
                r0_cnt_d      = r0_cnt_q - 3'd1;
            end
            if (r1_cnt_q != 3'd0) begin
                r1_org_h_d    = height_step(r1_org_h_q, r1_org_lfsr_q[0]);
                r1_org_lfsr_d = 7'(lfsr_step(24'(r1_org_lfsr_q), 24'(RIDGE1_TAPS)));
                r1_cnt_d      = r1_cnt_q - 3'd1;
            end
        end
    end

    always_comb begin
        r0_lfsr_d = r0_lfsr_q;
        r0_h_d    = r0_h_q;
        r1_lfsr_d = r1_lfsr_q;
        r1_h_d    = r1_h_q;
        if (!active) begin
            r0_lfsr_d = r0_org_lfsr_q;
            r0_h_d    = r0_org_h_q;
            r1_lfsr_d = r1_org_lfsr_q;
            r1_h_d    = r1_org_h_q;
        end else begin
            r0_h_d    = height_step(r0_h_q, r0_lfsr_q[0]);
            r0_lfsr_d = 8'(lfsr_step(24'(r0_lfsr_q), 24'(RIDGE0_TAPS)));
            r1_h_d    = height_step(r1_h_q, r1_lfsr_q[0]);
            // Ridge 1 walks at half horizontal rate for a smoother far skyline.
            if (!hpos[0]) begin
                r1_lfsr_d = 7'(lfsr_step(24'(r1_lfsr_q), 24'(RIDGE1_TAPS)));
            end
        end
    end

    always_comb begin
        pix_rgb = 3'd0;
        if (r1_h_q < vpos) pix_rgb = RIDGE1_RGB;
        if (r0_h_q < vpos) pix_rgb = RIDGE0_RGB;
        for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
            if (star_hit[i]) pix_rgb = star_rgb[i];
        end
        rgb_d = active ? pix_rgb : 3'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r0_org_lfsr_q <= RIDGE0_SEED;
            r0_org_h_q    <= 10'(RIDGE0_BASE);
            r0_cnt_q      <= 3'd0;
            r0_lfsr_q     <= RIDGE0_SEED;
            r0_h_q        <= 10'(RIDGE0_BASE);
            r1_org_lfsr_q <= RIDGE1_SEED;
            r1_org_h_q    <= 10'(RIDGE1_BASE);
            r1_cnt_q      <= 3'd0;
            r1_lfsr_q     <= RIDGE1_SEED;
            r1_h_q        <= 10'(RIDGE1_BASE);
            rgb_q         <= 3'd0;
        end else begin
            r0_org_lfsr_q <= r0_org_lfsr_d;
            r0_org_h_q    <= r0_org_h_d;
            r0_cnt_q      <= r0_cnt_d;
            r0_lfsr_q     <= r0_lfsr_d;
            r0_h_q        <= r0_h_d;
            r1_org_lfsr_q <= r1_org_lfsr_d;
            r1_org_h_q    <= r1_org_h_d;
            r1_cnt_q      <= r1_cnt_d;
            r1_lfsr_q     <= r1_lfsr_d;
            r1_h_q        <= r1_h_d;
            rgb_q         <= rgb_d;
        end
    end

    assign rgb = rgb_q;

endmodule

// File: doc/parallax_layers.md
Name: parallax_layers

Overview:
- Parametrised successor to the fixed 640x480 parallax background generator.
- Generates a procedural scrolling background from NUM_LAYERS LFSR starfield layers (layer i has 2^i horizontal pixel pitch) plus two random-walk mountain ridges.
- Timing comes from an external VGA sync generator. Scroll speed per layer is runtime-programmable and pausable; frame wrap uses per-frame seed stepping instead of resolution-specific magic constants.
- Output rgb feeds the top-level VGA pins.

Parameters:
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- NUM_LAYERS, 3: star layers, range 1..4.
- LFSR_W, 19: star LFSR width, range 16..24.
- DENSITY, 10: top LFSR bits that must all be 1 for a star; range 4..LFSR_W-3.
- RIDGE0_BASE, 400: ridge 0 origin height at reset.
- RIDGE1_BASE, 380: ridge 1 origin height at reset.

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- hpos  in  10  current pixel x.
- vpos  in  10  current pixel y.
- display_on  in  1  active video.
- scroll_en  in  1  1 = apply per-frame scrolling; 0 = frozen image.
- speed  in  3*(NUM_LAYERS+2)  packed per-layer steps/frame, 0..7. Index 0..NUM_LAYERS-1 are star layers, then ridge0, ridge1.
- rgb  out  3  registered pixel colour.

Behaviour:
- Reset:
  - All registers clear asynchronously on reset_n low; rgb=0.
  - Star frame seeds and pixel LFSRs reset to all-ones.
  - Ridge0: origin lfsr 8'h60, origin height RIDGE0_BASE.
  - Ridge1: origin lfsr 7'h30, origin height RIDGE1_BASE.
  - Ridge working registers reset equal to their origins.
- LFSR step: Galois right-shift, state <= (state>>1) ^ (state[0] ? TAPS : 0).
  - Star taps come from the package table indexed by LFSR_W.
  - Ridge0 taps 8'b10111000; ridge1 taps 7'b1100000.
- Vblank stepping:
  - Vblank is defined as vpos >= V_ACTIVE.
  - At the cycle with vpos==V_ACTIVE && hpos==0, each layer loads a down-counter with its speed field if scroll_en=1, else 0.
  - On each following cycle with counter>0: step that layer's frame seed (star) or origin lfsr (ridge), then decrement the counter.
  - Ridge origin height changes +1 if origin lfsr[0]==1 else -1, evaluated before the step; 10-bit wrap.
  - Stepping completes in at most 7 cycles.
- Star pixel LFSR:
  - While in vblank, the pixel LFSR is loaded with the frame seed every cycle, so it equals the seed at pixel (0,0).
  - On an active pixel where hpos[i-1:0]==0 (layer 0: every pixel), the pixel LFSR steps after use.
  - Otherwise it holds, including hblank.
  - Net effect: speed=1 shifts the layer raster one layer-pixel left per frame, wrapping into the previous line.
- Star hit, layer i: display_on && hpos[i-1:0]==0 && top DENSITY bits all 1. Colour = lfsr[2:0]; a value of 0 is forced to 3'b111.
- Ridge working registers:
  - When display_on=0, the working lfsr and height reload from the origin registers.
  - On each active pixel, ridge0 steps its lfsr and moves height ±1 by lfsr[0] (before the step).
  - Ridge1 steps its lfsr only when hpos[0]==0, but updates height every active pixel.
  - Ridge i is hit when height_i < vpos.
- Colour priority: lowest-index star hit > ridge0 (3'b010) > ridge1 (3'b100) > 0. Ridge colours replace the additive mixing of the earlier block.
- Output:
  - rgb is registered, with 1-cycle latency from hpos/vpos/display_on.
  - rgb=0 whenever display_on was 0 in the sampling cycle.
- Boundaries:
  - speed=0 or scroll_en=0 gives an identical image every frame.
  - A speed change mid-frame takes effect at the next vblank start.
  - If reset_n asserts mid-frame, output goes to 0 immediately; the next frame after release restarts from the reset seeds.
  - Ridge heights wrap modulo 1024: 0-1 becomes 1023 (ridge invisible), 1023+1 becomes 0.

Decomposition:
- Package parallax_pkg holds:
  - the LFSR_W-indexed star taps table (16..24), as a function;
  - ridge taps;
  - RIDGE0_RGB, RIDGE1_RGB and STAR_FORCE_RGB constants;
  - the shared Galois step function.
- Sub-module parallax_star_layer (params LFSR_W, DENSITY, PITCH_LOG2) holds the seed register, pixel LFSR, vblank down-counter and hit/colour logic. It is instantiated NUM_LAYERS times in a generate loop.
- Ridges stay in the top module.

Test Plan:
- Reset check: assert reset_n=0 mid-line -> rgb=0 same cycle. After release, layer seeds read 2^LFSR_W-1, and ridge0 working height at first active pixel = 400.
- Freeze check: scroll_en=0, speed all 7, capture 3 frames -> all frames bit-identical.
- Scroll check: NUM_LAYERS=1, ridges' speed=0, layer0 speed=1, scroll_en=1 -> frame N+1 star pixel k equals frame N star pixel k+1 for all k < H_ACTIVE*V_ACTIVE-1.
- Pitch check: layer 1 only (layer0 DENSITY forced unreachable by model) -> no star on odd hpos; frame star count matches reference model (LFSR_W=16, DENSITY=8).
- Ridge check: line 0 after reset -> ridge0 height sequence starts 400, then ±1 per pixel following lfsr 8'h60 bit0 (first step -1 to 399). Pixels with vpos>height show 3'b010 when no star.
- Blanking check: display_on=0 for a full hblank -> rgb=0 one cycle after each blank cycle. Ridge working registers equal origins at next line start.
